// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
// Pure declarations; no logic, no latency, no flow control.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_NINE  = 4'd9;
    localparam logic [3:0]  BCD_FIVE  = 4'd5;
    localparam logic [15:0] ZERO_TIME = 16'h0000;

    function automatic logic bcd_valid(input logic [7:0] mm, input logic [7:0] ss);
        return (mm[7:4] <= BCD_NINE) && (mm[3:0] <= BCD_NINE) &&
               (ss[7:4] <= BCD_FIVE) && (ss[3:0] <= BCD_NINE);
    endfunction

    // One-second decrement of {mm,ss}; seconds tens wrap to 5, all others to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = BCD_NINE;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = BCD_FIVE;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = BCD_NINE;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes the divider's slow square wave and flags its rising edges.
// tick_rise is high SYNC_STAGES cycles after tick_in rises; no backpressure.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rstn,
    input  logic tick_in,
    output logic tick_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown with load/start/pause; optional alarm blink via TIMER_BLINK_EN.
// Decrement lands SYNC_STAGES+1 cycles after a tick_in rise; no backpressure.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_MM      = 8'h01,
    parameter logic [7:0] RST_SS      = 8'h00
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       tick_in,
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
`ifdef TIMER_BLINK_EN
    ,
    output logic       alarm
`endif
);

    logic        tick_rise;
    state_t      state_q, state_d;
    logic [15:0] time_q, time_d;
    logic        running_q, done_q, expired_q, load_err_q;
    logic        expired_d, load_err_d;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clkin     (clkin),
        .rstn      (rstn),
        .tick_in   (tick_in),
        .tick_rise (tick_rise)
    );

    // A load outside RUN pre-empts every other control in the same cycle.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (load && (state_q != RUN)) begin
            if (bcd_valid(load_mm, load_ss)) begin
                time_d  = {load_mm, load_ss};
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (time_q != ZERO_TIME)) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick_rise) begin
                        time_d = bcd_dec(time_q);
                        if (time_d == ZERO_TIME) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) state_d = RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q    <= IDLE;
            time_q     <= {RST_MM, RST_SS};
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign mm       = time_q[15:8];
    assign ss       = time_q[7:0];
    assign running  = running_q;
    assign done     = done_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

`ifdef TIMER_BLINK_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = 1'b0;
        if (state_d == DONE) begin
            if (state_q != DONE) alarm_d = 1'b1;
            else if (tick_rise)  alarm_d = ~alarm_q;
            else                 alarm_d = alarm_q;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstn) alarm_q <= 1'b0;
        else       alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: drives after each rising edge, samples 1ns later.
// Covers reset, BCD borrow, expiry, pause/resume, load rejection and event priorities.
module tb_countdown_timer;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] mm, ss;
    logic       running, done, expired, load_err;
`ifdef TIMER_BLINK_EN
    logic       alarm;
`endif

    int checks = 0;
    int passed = 0;

    countdown_timer dut (
        .clkin    (clkin),
        .rstn     (rstn),
        .tick_in  (tick_in),
        .load     (load),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
        .start    (start),
        .pause    (pause),
        .mm       (mm),
        .ss       (ss),
        .running  (running),
        .done     (done),
        .expired  (expired),
        .load_err (load_err)
`ifdef TIMER_BLINK_EN
        ,
        .alarm    (alarm)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ld(input logic [7:0] m, input logic [7:0] s);
        load_mm = m;
        load_ss = s;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    // Raise tick_in and wait until the decrement edge (SYNC_STAGES+1 = 3 edges).
    task automatic tick_hi();
        tick_in = 1'b1;
        step(); step(); step();
    endtask

    task automatic tick_lo();
        tick_in = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        step(); step();
        rstn = 1'b1;
        step();
        check("rst_mm", {8'h0, mm}, 16'h01);
        check("rst_ss", {8'h0, ss}, 16'h00);
        check("rst_running", {15'h0, running}, 16'h0);
        check("rst_done", {15'h0, done}, 16'h0);
        check("rst_expired", {15'h0, expired}, 16'h0);
        check("rst_load_err", {15'h0, load_err}, 16'h0);
`ifdef TIMER_BLINK_EN
        check("rst_alarm", {15'h0, alarm}, 16'h0);
`endif
        tick_hi(); tick_lo();
        check("idle_tick_time", {mm, ss}, 16'h0100);

        ld(8'h00, 8'h03);
        check("load_0003", {mm, ss}, 16'h0003);
        check("load_ok_no_err", {15'h0, load_err}, 16'h0);
        pulse_start();
        check("start_running", {15'h0, running}, 16'h1);
        tick_in = 1'b1;
        step(); step();
        check("tick_latency_early", {mm, ss}, 16'h0003);
        step();
        check("tick_latency_exact", {mm, ss}, 16'h0002);
        tick_lo();
        tick_hi();
        check("dec_to_01", {mm, ss}, 16'h0001);
        tick_lo();
        tick_hi();
        check("dec_to_00", {mm, ss}, 16'h0000);
        check("expired_pulse", {15'h0, expired}, 16'h1);
        check("done_on_expiry", {15'h0, done}, 16'h1);
        check("running_off_expiry", {15'h0, running}, 16'h0);
`ifdef TIMER_BLINK_EN
        check("alarm_entry", {15'h0, alarm}, 16'h1);
`endif
        step();
        check("expired_one_cycle", {15'h0, expired}, 16'h0);
        check("done_held", {15'h0, done}, 16'h1);
        tick_lo();
        tick_hi();
        check("done_tick_holds", {mm, ss}, 16'h0000);
        check("done_tick_no_expired", {15'h0, expired}, 16'h0);
`ifdef TIMER_BLINK_EN
        check("alarm_toggle0", {15'h0, alarm}, 16'h0);
        tick_lo();
        tick_hi();
        check("alarm_toggle1", {15'h0, alarm}, 16'h1);
`endif
        tick_lo();
        pulse_start();
        check("done_start_ignored", {15'h0, running}, 16'h0);

        ld(8'h10, 8'h00);
        check("load_from_done", {mm, ss}, 16'h1000);
        check("load_leaves_done", {15'h0, done}, 16'h0);
`ifdef TIMER_BLINK_EN
        check("alarm_off_idle", {15'h0, alarm}, 16'h0);
`endif
        pulse_start();
        tick_hi();
        check("borrow_chain", {mm, ss}, 16'h0959);
        tick_lo();
        ld(8'h00, 8'h30);
        check("load_in_run_ignored", {mm, ss}, 16'h0959);
        check("load_in_run_no_err", {15'h0, load_err}, 16'h0);
        check("load_in_run_still_running", {15'h0, running}, 16'h1);

        pulse_pause();
        check("pause_stops", {15'h0, running}, 16'h0);
        tick_hi(); tick_lo();
        check("pause_no_dec", {mm, ss}, 16'h0959);
        ld(8'h00, 8'h05);
        check("load_in_pause", {mm, ss}, 16'h0005);
        pulse_start();
        pulse_pause();
        tick_hi(); tick_lo();
        tick_hi(); tick_lo();
        check("paused_two_ticks", {mm, ss}, 16'h0005);
        pulse_start();
        check("resume_running", {15'h0, running}, 16'h1);
        tick_hi();
        check("resume_dec", {mm, ss}, 16'h0004);
        tick_lo();

        pause = 1'b1;
        start = 1'b1;
        step();
        pause = 1'b0;
        start = 1'b0;
        check("pause_beats_start", {15'h0, running}, 16'h0);

        ld(8'h0A, 8'h00);
        check("bad_mm_err", {15'h0, load_err}, 16'h1);
        check("bad_mm_unchanged", {mm, ss}, 16'h0004);
        step();
        check("load_err_one_cycle", {15'h0, load_err}, 16'h0);
        ld(8'h00, 8'h60);
        check("bad_ss_err", {15'h0, load_err}, 16'h1);
        check("bad_ss_unchanged", {mm, ss}, 16'h0004);

        load_mm = 8'h00;
        load_ss = 8'h42;
        load = 1'b1;
        start = 1'b1;
        step();
        load = 1'b0;
        start = 1'b0;
        check("load_beats_start_time", {mm, ss}, 16'h0042);
        check("load_beats_start_idle", {15'h0, running}, 16'h0);
        pulse_start();
        check("run_at_42", {15'h0, running}, 16'h1);
        rstn = 1'b0;
        step();
        check("midrun_reset_time", {mm, ss}, 16'h0100);
        check("midrun_reset_running", {15'h0, running}, 16'h0);
        check("midrun_reset_no_expired", {15'h0, expired}, 16'h0);
        rstn = 1'b1;
        step();

        ld(8'h00, 8'h00);
        pulse_start();
        check("start_at_zero_ignored", {15'h0, running}, 16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Consumes the slow square wave produced by the clock divider; each rising edge of that wave counts as one second.
- Runs an MM:SS BCD countdown with load, start and pause controls.
- Drives the digit outputs for the display stage and flags expiry.
- Runs entirely on the fast board clock; the slow wave is treated as data, never as a clock.

Parameters:
- SYNC_STAGES, 2, number of flops synchronizing tick_in (minimum 2).
- RST_MM, 8'h01, BCD minutes value loaded at reset.
- RST_SS, 8'h00, BCD seconds value loaded at reset.

Ports:
- clkin  input  1  board clock; all logic on its rising edge.
- rstn  input  1  synchronous, active-low reset.
- tick_in  input  1  slow square wave from the divider; one rising edge = one second.
- load  input  1  one-cycle pulse; loads load_mm/load_ss.
- load_mm  input  8  BCD minutes {tens,units}, each digit 0-9.
- load_ss  input  8  BCD seconds {tens 0-5, units 0-9}.
- start  input  1  one-cycle pulse; begin or resume the countdown.
- pause  input  1  one-cycle pulse; freeze the countdown.
- mm  output  8  current BCD minutes.
- ss  output  8  current BCD seconds.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- expired  output  1  one-cycle pulse on entry to DONE.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock, clkin. Reset rstn is synchronous and active-low, sampled on clkin rising edge.
- Reset values:
  - mm=RST_MM, ss=RST_SS.
  - running, done, expired, load_err all 0.
  - State = IDLE; synchronizer and edge-detect flops cleared.
  - Reset asserted mid-countdown aborts it with no expired pulse.
- Tick detection:
  - tick_in passes through SYNC_STAGES flops, then a one-flop rising-edge detect, producing tick_rise.
  - The decrement is visible on mm/ss SYNC_STAGES+1 clkin cycles after the tick_in rising edge.
  - Falling edges are ignored.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: start with mm:ss != 00:00 goes to RUN. start at 00:00 is ignored.
  - RUN: tick_rise decrements. pause goes to PAUSE.
  - PAUSE: tick_rise is ignored. start goes to RUN.
  - DONE: holds 00:00. load goes to IDLE; start is ignored until a nonzero load.
- Decrement (BCD borrow chain):
  - ss units 0 wraps to 9 and borrows from ss tens.
  - ss tens 0 wraps to 5 and borrows from mm units.
  - mm units 0 wraps to 9 and borrows from mm tens.
  - Example: 10:00 becomes 09:59.
- Expiry: a decrement from 00:01 to 00:00 enters DONE on the same edge mm/ss become 00:00. expired pulses that cycle; done is high from that cycle on.
- Load:
  - Accepted in IDLE, PAUSE and DONE, effective on the next edge; the state becomes IDLE.
  - In RUN, load is ignored; no load_err.
  - Rejected when any BCD digit exceeds 9 or the ss tens digit exceeds 5: mm/ss are unchanged and load_err pulses.
- Simultaneous events:
  - load with start: load wins; start is dropped.
  - pause with start: pause wins.
  - pause with tick_rise in RUN: no decrement.
  - start with tick_rise in PAUSE: enter RUN, no decrement that cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TIMER_BLINK_EN.
- Defined:
  - Adds output port alarm (1 bit).
  - In DONE, alarm toggles on each tick_rise, starting at 1 on DONE entry.
  - alarm is 0 in every other state and at reset.
- Undefined: no alarm port and no blink logic; all other behaviour is identical.

Decomposition:
- Package timer_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD constants: BCD_NINE=4'd9, BCD_FIVE=4'd5, ZERO_TIME=16'h0000.
  - Function bcd_valid(mm,ss) used by the load check.
- Sub-module tick_sync holds the SYNC_STAGES synchronizer and rising-edge detect. Ports: clkin, rstn, tick_in, tick_rise. It is reusable by other stages fed from the divider.

Test Plan:
- Reset, then hold: mm=8'h01, ss=8'h00, running=0, done=0. A tick_in edge produces no change.
- Load 00:03, start, three tick_in edges: ss goes 03, 02, 01, 00. On the third edge, expired is a single pulse, done=1, running=0. A fourth edge changes nothing.
- Load 10:00, start, one edge: mm=8'h09, ss=8'h59 (borrow chain across all digits).
- Load 00:05, start, pause, two edges, then start and one edge: mm:ss goes 00:05, then holds 00:05 while paused, then 00:04.
- Load mm=8'h0A or ss=8'h60: load_err pulses and mm:ss are unchanged. load in RUN: ignored, no load_err.
- Assert rstn=0 mid-run at 00:42: next cycle shows mm=8'h01, ss=8'h00, IDLE. With TIMER_BLINK_EN, alarm goes 1, 0, 1 on successive edges in DONE.
